// File: rtl/piano_key_scheduler.sv
// rtl/piano_key_scheduler.sv - PS/2 set-2 note-key decoder publishing a frame-synchronous highlight mask
// Optional PIANO_KEY_TOGGLE_EN: each physical press toggles its key instead of momentary hold.
module piano_key_scheduler #(
    parameter int VSYNC_ACTIVE_LOW = 1,
    parameter int HOLD_FRAMES      = 4,
    parameter int PREFIX_TIMEOUT   = 1000000
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [7:0]  iScanCode,
    input  logic        iScanValid,
    input  logic        iVerticalSync,
    output logic [11:0] oKeyMask,
    output logic [3:0]  oActiveNote,
    output logic        oNoteValid,
    output logic        oFrameTick
);
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_BRK     = 2'd1;
    localparam logic [1:0] ST_EXT     = 2'd2;
    localparam logic [1:0] ST_EXT_BRK = 2'd3;

    localparam int           TW       = $clog2(PREFIX_TIMEOUT + 1);
    localparam logic [TW-1:0] TMR_MAX = TW'(PREFIX_TIMEOUT);
    localparam logic         VS_IDLE  = (VSYNC_ACTIVE_LOW != 0);

    logic [1:0]    state_q, state_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic          vs_meta_q, vs_sync_q, act_prev_q;
    logic          act, boundary;
    logic [11:0]   held_q, held_d;
    logic [11:0]   make_ev, brk_ev, pub;
    logic [11:0]   mask_q;
    logic [3:0]    note_q, note_d;
    logic          valid_q, tick_q;
    logic [4:0]    key;

    // {hit, note index}
    function automatic logic [4:0] key_lookup(input logic [7:0] code);
        case (code)
            8'h1C: return 5'h10;
            8'h1D: return 5'h11;
            8'h1B: return 5'h12;
            8'h24: return 5'h13;
            8'h23: return 5'h14;
            8'h2B: return 5'h15;
            8'h2C: return 5'h16;
            8'h34: return 5'h17;
            8'h35: return 5'h18;
            8'h33: return 5'h19;
            8'h3C: return 5'h1A;
            8'h3B: return 5'h1B;
            default: return 5'h00;
        endcase
    endfunction

    assign key      = key_lookup(iScanCode);
    assign act      = vs_sync_q ^ VS_IDLE;
    assign boundary = act_prev_q & ~act;

    always_comb begin
        state_d = state_q;
        make_ev = '0;
        brk_ev  = '0;
        if (iScanValid) begin
            case (state_q)
                ST_IDLE: begin
                    if (iScanCode == 8'hF0)      state_d = ST_BRK;
                    else if (iScanCode == 8'hE0) state_d = ST_EXT;
                    else if (key[4])             make_ev = 12'b1 << key[3:0];
                end
                ST_BRK: begin
                    state_d = ST_IDLE;
                    if (key[4]) brk_ev = 12'b1 << key[3:0];
                end
                ST_EXT:  state_d = (iScanCode == 8'hF0) ? ST_EXT_BRK : ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end else if (state_q != ST_IDLE && tmr_q == TMR_MAX) begin
            state_d = ST_IDLE;
        end
    end

    assign tmr_d = iScanValid ? '0 : ((tmr_q == TMR_MAX) ? tmr_q : tmr_q + TW'(1));

`ifdef PIANO_KEY_TOGGLE_EN
    logic [11:0] down_q, down_d;

    // The down flag swallows typematic repeats so one press toggles once.
    always_comb begin
        down_d = (down_q | make_ev) & ~brk_ev;
        held_d = held_q ^ (make_ev & ~down_q);
        pub    = held_q;
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) down_q <= '0;
        else       down_q <= down_d;
    end
`else
    localparam logic [2:0] HOLD = 3'(HOLD_FRAMES);
    logic [11:0][2:0] cnt_q, cnt_d;

    // A make reload takes priority over the boundary decrement.
    always_comb begin
        held_d = (held_q | make_ev) & ~brk_ev;
        for (int k = 0; k < 12; k++) begin
            cnt_d[k] = cnt_q[k];
            if (make_ev[k])                      cnt_d[k] = HOLD;
            else if (boundary && cnt_q[k] != '0) cnt_d[k] = cnt_q[k] - 3'd1;
            pub[k] = held_q[k] | (cnt_q[k] != '0);
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
`endif

    always_comb begin
        note_d = '0;
        for (int k = 11; k >= 0; k--) begin
            if (pub[k]) note_d = 4'(k);
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q    <= ST_IDLE;
            tmr_q      <= '0;
            vs_meta_q  <= VS_IDLE;
            vs_sync_q  <= VS_IDLE;
            act_prev_q <= 1'b0;
            held_q     <= '0;
            mask_q     <= '0;
            note_q     <= '0;
            valid_q    <= 1'b0;
            tick_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tmr_q      <= tmr_d;
            vs_meta_q  <= iVerticalSync;
            vs_sync_q  <= vs_meta_q;
            act_prev_q <= act;
            held_q     <= held_d;
            tick_q     <= boundary;
            if (boundary) begin
                mask_q  <= pub;
                note_q  <= note_d;
                valid_q <= |pub;
            end
        end
    end

    assign oKeyMask    = mask_q;
    assign oActiveNote = note_q;
    assign oNoteValid  = valid_q;
    assign oFrameTick  = tick_q;
endmodule

// File: doc/piano_key_scheduler.md
Name: piano_key_scheduler

Overview:
- Sits between the PS/2 keyboard receiver and the VGA piano drawer.
- Decodes the set-2 scan-code byte stream (make, break and E0 prefixes) with an FSM and tracks the held state of the 12 note keys.
- Enforces a minimum on-screen time for short taps.
- Publishes a key-highlight mask that changes only at frame boundaries, so the drawer never shows a half-updated keyboard within one frame.

Parameters:
- VSYNC_ACTIVE_LOW, 1: polarity of iVerticalSync (1 = sync pulse is low).
- HOLD_FRAMES, 4: minimum number of published frames a key stays lit after a make code (range 1..7).
- PREFIX_TIMEOUT, 1000000: Clock cycles after an F0/E0 prefix before the FSM abandons it and returns to IDLE.

Ports:
- Clock  in  1  system clock.
- Reset  in  1  asynchronous, active-high reset.
- iScanCode  in  8  received scan-code byte.
- iScanValid  in  1  one-cycle strobe: iScanCode is valid.
- iVerticalSync  in  1  VGA vertical sync from the timing generator; asynchronous-safe.
- oKeyMask  out  12  published highlight mask, bit0=C .. bit11=B.
- oActiveNote  out  4  index of the lowest set bit of oKeyMask.
- oNoteValid  out  1  oKeyMask != 0.
- oFrameTick  out  1  one-cycle pulse on each frame boundary.

Behaviour:
- Reset: all registers clear asynchronously; oKeyMask=0, oActiveNote=0, oNoteValid=0, oFrameTick=0, FSM=IDLE, all hold counters=0.
- Key map (set-2 codes to note bits): 1C=0, 1D=1, 1B=2, 24=3, 23=4, 2B=5, 2C=6, 34=7, 35=8, 33=9, 3C=10, 3B=11. Any other code is ignored.
- FSM states: IDLE, BRK, EXT, EXT_BRK. Only cycles with iScanValid=1 advance the FSM, except for the timeout.
  - IDLE: F0 -> BRK; E0 -> EXT; mapped code -> make event, stay in IDLE; other codes -> IDLE.
  - BRK: mapped code -> break event, then IDLE; any other byte -> IDLE, no event.
  - EXT: F0 -> EXT_BRK; any other byte -> IDLE, no event (extended keys are ignored).
  - EXT_BRK: any byte -> IDLE, no event.
  - Timeout: a cycle counter clears on every iScanValid. When it reaches PREFIX_TIMEOUT in BRK, EXT or EXT_BRK, the FSM returns to IDLE.
- Make event on bit k: rHeld[k] <= 1 and cnt[k] <= HOLD_FRAMES. Typematic repeats of a held key reload cnt[k]; there are no other effects.
- Break event on bit k: rHeld[k] <= 0. cnt[k] is untouched.
- Frame boundary:
  - iVerticalSync passes through a 2-FF synchronizer.
  - A boundary is the end of the sync pulse, i.e. the active -> inactive transition of the synchronized signal.
  - oFrameTick=1 for exactly the one cycle after the boundary is detected.
- On the boundary cycle:
  - oKeyMask <= rHeld | (cnt != 0), per bit.
  - Each nonzero cnt decrements by 1 in the same cycle.
  - Zero counters stay at 0.
- Between boundaries oKeyMask is held constant.
- oActiveNote and oNoteValid are registered and update in the same cycle as oKeyMask. When the mask is 0, oActiveNote=0.
- Simultaneous events:
  - A scan event in the boundary cycle is not visible in that publish. The publish uses pre-event register values; the event appears at the next boundary.
  - A make in the same cycle as a cnt decrement: the reload wins.
- Latency: key-to-display is at most 1 frame plus 3 cycles after the iScanValid strobe.
- Reset asserted mid-frame or mid-prefix clears everything. Publishing resumes at the first boundary after release.

Optional Feature:
- Macro: PIANO_KEY_TOGGLE_EN.
- Defined:
  - A make event toggles rHeld[k]; break events are ignored.
  - Typematic repeats (a make for k arriving before the break for k) are suppressed by a per-key "down" flag, so a key toggles once per physical press.
  - cnt is not used, and oKeyMask <= rHeld at each boundary.
- Undefined: momentary behaviour as described in Behaviour.

Test Plan:
- Reset released, vsync running, no scan codes -> oKeyMask=000 every frame; oFrameTick pulses once per frame; oNoteValid=0.
- Bytes 23, then F0 23 after 10 frames -> bit4 set from the first boundary after the make through the boundary following the break; oActiveNote=4; bit4=0 afterwards.
- Tap: 1C then F0 1C both within one frame, HOLD_FRAMES=4 -> oKeyMask=001 for exactly 4 consecutive boundaries, then 000.
- Chord: 3B, 1B, 33 -> oKeyMask=A04, oActiveNote=2; then F0 1B -> oKeyMask=A00, oActiveNote=9.
- Prefix: E0 F0 23 -> no mask change. F0, then idle for PREFIX_TIMEOUT+1 cycles, then 23 -> treated as a make, so bit4 is set.
- Make 2B issued in the exact boundary cycle -> that publish omits bit5; the next boundary shows bit5 set. Reset pulsed mid-frame -> all outputs are 0 immediately.
